// File: rtl/mmio_port_responder_if.sv
// Data-bus view of the MMIO responder: the same load/store signals the data RAM sees,
// plus the Hit/ReadData pair the top level uses to steer the load mux.
`timescale 1ns/1ps
interface mmio_port_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (output Address, WriteData, MemWrite, MemRead, input ReadData, Hit);
  modport slave  (input Address, WriteData, MemWrite, MemRead, output ReadData, Hit);
endinterface

// File: rtl/mmio_port_responder.sv
// MMIO responder: 32-bit output port, synchronized 8-bit input port, and a change-capture
// FIFO that software polls or pops through a 32-byte register window.
`timescale 1ns/1ps
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0020,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_port_responder_if.slave bus,
  input  logic [7:0]           PortIn,
  output logic [31:0]          PortOut,
  output logic                 Irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] OFF_PORT_OUT = 3'd0;
  localparam logic [2:0] OFF_PORT_IN  = 3'd1;
  localparam logic [2:0] OFF_STATUS   = 3'd2;
  localparam logic [2:0] OFF_POP      = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  prev_q;
  logic [FIFO_DEPTH-1:0][7:0]  mem_q;
  logic [PW-1:0]               wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        ovf_q, ovf_d;
  logic [31:0]                 port_out_q, port_out_d;

  logic [7:0] sync_out;
  logic       hit, rd_en, wr_en, empty, full;
  logic       push, pop, flush, clr_ovf, do_push, do_pop, ovf_set;
  logic [2:0] off;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign hit      = bus.Address[31:5] == BASE_ADDR[31:5];
  assign off      = bus.Address[4:2];
  assign rd_en    = bus.MemRead & hit;
  assign wr_en    = bus.MemWrite & hit;
  assign empty    = count_q == '0;
  assign full     = count_q == CW'(FIFO_DEPTH);

  assign push    = sync_out != prev_q;
  assign pop     = rd_en && off == OFF_POP && !empty;
  assign flush   = wr_en && off == OFF_CTRL && bus.WriteData[1];
  assign clr_ovf = wr_en && off == OFF_CTRL && bus.WriteData[0];

  // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands;
  // flush overrides both and suppresses the overflow the dropped sample would cause.
  assign do_push = push && (!full || pop) && !flush;
  assign do_pop  = pop && !flush;
  assign ovf_set = push && full && !pop && !flush;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + PW'(1);
      if (do_pop)  rp_d = rp_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    ovf_d      = (ovf_q & ~clr_ovf) | ovf_set;
    port_out_d = (wr_en && off == OFF_PORT_OUT) ? bus.WriteData : port_out_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      prev_q     <= '0;
      mem_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      port_out_q <= '0;
    end else begin
      sync_q[0] <= PortIn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_out;
      if (do_push) mem_q[wp_q] <= sync_out;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      port_out_q <= port_out_d;
    end
  end

  // Reads see pre-edge state, so a combined read/write returns the old value.
  always_comb begin
    bus.ReadData = '0;
    if (rd_en) begin
      case (off)
        OFF_PORT_OUT: bus.ReadData = port_out_q;
        OFF_PORT_IN:  bus.ReadData = {24'b0, sync_out};
        OFF_STATUS:   bus.ReadData = {24'b0, 5'(count_q), ovf_q, full, empty};
        OFF_POP:      bus.ReadData = empty ? 32'b0 : {24'b0, mem_q[rp_q]};
        default:      bus.ReadData = '0;
      endcase
    end
  end

  assign bus.Hit = hit;
  assign PortOut = port_out_q;
  assign Irq     = !empty;
endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed bench for mmio_port_responder: register access, input capture, FIFO edge cases, reset.
`timescale 1ns/1ps
module tb_mmio_port_responder;
  localparam logic [31:0] BASE = 32'h1001_0020;

  logic        clk;
  logic        reset;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        Irq;
  int          total = 0;
  int          bad   = 0;

  mmio_port_responder_if bus ();

  mmio_port_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .PortIn(PortIn), .PortOut(PortOut), .Irq(Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One-cycle load: sample mid-cycle, then let the edge end the access.
  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.Address = addr; bus.MemRead = 1'b1;
    @(negedge clk);
    chk(tag, bus.ReadData, exp);
    tick();
    bus.MemRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    bus.Address = addr; bus.WriteData = d; bus.MemWrite = 1'b1;
    tick();
    bus.MemWrite = 1'b0;
  endtask

  task automatic change(input logic [7:0] v);
    PortIn = v; tick(); tick();
  endtask

  initial begin
    reset = 1'b0; PortIn = 8'h00;
    bus.Address = BASE; bus.WriteData = '0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;

    // reset state
    #3;
    chk("rst_portout", PortOut, 32'h0);
    chk("rst_irq", {31'b0, Irq}, 32'h0);
    bus.Address = BASE + 32'h8; bus.MemRead = 1'b1; #1;
    chk("rst_status", bus.ReadData, 32'h1);
    chk("rst_hit", {31'b0, bus.Hit}, 32'h1);
    bus.MemRead = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // output port write
    bus.Address = BASE; bus.WriteData = 32'hDEAD_BEEF; bus.MemWrite = 1'b1;
    @(negedge clk);
    chk("pout_before_edge", PortOut, 32'h0);
    tick(); bus.MemWrite = 1'b0;
    chk("pout_after_edge", PortOut, 32'hDEAD_BEEF);
    rd_chk("pout_read", BASE, 32'hDEAD_BEEF);
    rd_chk("pout_read_bytebits", BASE + 32'h3, 32'hDEAD_BEEF);

    // synchronizer and capture
    PortIn = 8'h5A; bus.Address = BASE + 32'h4; bus.MemRead = 1'b1;
    @(negedge clk); chk("pin_pre", bus.ReadData, 32'h0); tick();
    @(negedge clk); chk("pin_edge1", bus.ReadData, 32'h0); tick();
    @(negedge clk); chk("pin_edge2", bus.ReadData, 32'h5A);
    chk("irq_before_push", {31'b0, Irq}, 32'h0); tick();
    @(negedge clk); chk("irq_after_push", {31'b0, Irq}, 32'h1); tick();
    bus.MemRead = 1'b0;
    rd_chk("status_cnt1", BASE + 32'h8, 32'h08);
    rd_chk("pop_5a", BASE + 32'hC, 32'h5A);
    rd_chk("status_empty", BASE + 32'h8, 32'h01);
    chk("irq_cleared", {31'b0, Irq}, 32'h0);

    // fill and overflow
    for (int v = 1; v <= 5; v++) change(8'(v));
    tick(); tick();
    rd_chk("status_full_ovf", BASE + 32'h8, 32'h26);
    for (int v = 1; v <= 4; v++) rd_chk("pop_fill", BASE + 32'hC, 32'(v));
    rd_chk("pop_empty", BASE + 32'hC, 32'h0);
    rd_chk("status_ovf_sticky", BASE + 32'h8, 32'h05);
    wr(BASE + 32'h10, 32'h1);
    rd_chk("status_ovf_clr", BASE + 32'h8, 32'h01);

    // simultaneous push and pop while full, across pointer wrap
    for (int v = 8'h11; v <= 8'h14; v++) change(8'(v));
    tick(); tick();
    rd_chk("status_full", BASE + 32'h8, 32'h22);
    PortIn = 8'h15; tick(); tick();
    rd_chk("pop_with_push", BASE + 32'hC, 32'h11);
    rd_chk("status_pushpop", BASE + 32'h8, 32'h22);
    for (int v = 8'h12; v <= 8'h15; v++) rd_chk("pop_wrap", BASE + 32'hC, 32'(v));
    rd_chk("status_drained", BASE + 32'h8, 32'h01);

    // flush racing an incoming change
    change(8'h21); change(8'h22); tick(); tick();
    rd_chk("status_two", BASE + 32'h8, 32'h10);
    PortIn = 8'h23; tick(); tick();
    wr(BASE + 32'h10, 32'h2);
    rd_chk("status_flushed", BASE + 32'h8, 32'h01);
    tick(); tick();
    rd_chk("status_no_late_push", BASE + 32'h8, 32'h01);

    // decode boundaries
    bus.Address = BASE + 32'h14; bus.MemRead = 1'b1;
    @(negedge clk);
    chk("hole_hit", {31'b0, bus.Hit}, 32'h1);
    chk("hole_data", bus.ReadData, 32'h0);
    tick(); bus.MemRead = 1'b0;
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    chk("hole_write_ignored", PortOut, 32'hDEAD_BEEF);
    bus.Address = BASE + 32'h20; bus.MemRead = 1'b1;
    @(negedge clk);
    chk("miss_hit", {31'b0, bus.Hit}, 32'h0);
    chk("miss_data", bus.ReadData, 32'h0);
    tick(); bus.MemRead = 1'b0;
    wr(BASE + 32'h20, 32'h5555_5555);
    chk("miss_write_ignored", PortOut, 32'hDEAD_BEEF);

    // read and write together: old value read, new value written
    bus.Address = BASE; bus.WriteData = 32'h1234; bus.MemWrite = 1'b1; bus.MemRead = 1'b1;
    @(negedge clk);
    chk("rw_old_value", bus.ReadData, 32'hDEAD_BEEF);
    tick(); bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    chk("rw_new_value", PortOut, 32'h1234);

    // reset mid-operation
    change(8'h31); change(8'h32); change(8'h33); tick(); tick();
    rd_chk("status_three", BASE + 32'h8, 32'h18);
    @(negedge clk); #2;
    reset = 1'b0; #1;
    chk("midrst_portout", PortOut, 32'h0);
    chk("midrst_irq", {31'b0, Irq}, 32'h0);
    bus.Address = BASE + 32'h8; bus.MemRead = 1'b1; #1;
    chk("midrst_status", bus.ReadData, 32'h01);
    bus.MemRead = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    chk("release_capture_irq", {31'b0, Irq}, 32'h1);
    rd_chk("release_capture_pop", BASE + 32'hC, 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_port_responder.md
# mmio_port_responder

Memory-mapped I/O responder on the processor's data bus: it answers the same MemWrite/MemRead/Address/WriteData/ReadData transactions that the data RAM serves. It owns the 32-bit output port register and synchronizes the 8-bit input port. It records every input change in a small FIFO so software can poll or pop changes with plain lw/sw instructions. The top level muxes ReadData between RAM and this block using Hit.

## Interface
- BASE_ADDR, 32'h1001_0020: base of a 32-byte aligned register window.
- FIFO_DEPTH, 4: change-capture FIFO entries; power of two, 2..16.
- SYNC_STAGES, 2: PortIn synchronizer flops; minimum 2.
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low; clears all state.
- Address, input, 32: byte address from the ALU result.
- WriteData, input, 32: store data.
- MemWrite, input, 1: store strobe, qualified by Hit.
- MemRead, input, 1: load strobe, qualified by Hit.
- ReadData, output, 32: load data; combinational.
- Hit, output, 1: Address[31:5] == BASE_ADDR[31:5].
- PortIn, input, 8: asynchronous external input.
- PortOut, output, 32: output port register.
- Irq, output, 1: FIFO not empty.

## Operation
- Decode uses Address[4:2] as word offset. Address[1:0] is ignored.
- 0x00 PORT_OUT (R/W): a write loads WriteData into PortOut. A read returns PortOut.
- 0x04 PORT_IN (RO): read returns {24'b0, sync_out}, where sync_out is the last synchronizer stage.
- 0x08 STATUS (RO): [0] empty, [1] full, [2] overflow (sticky), [7:3] count (0..FIFO_DEPTH). All other bits read 0.
- 0x0C FIFO_POP (RO with side effect):
  - If not empty: the read returns {24'b0, oldest entry}, and the entry is popped at the clock edge ending the access cycle.
  - If empty: the read returns 0 and the FIFO is unchanged.
- 0x10 CTRL (WO, reads 0): bit0=1 clears overflow; bit1=1 flushes the FIFO (count←0). Other bits are ignored.
- Offsets 0x14–0x1C: reads return 0; writes are ignored.
- Hit is still asserted for every address in the 32-byte window.
- ReadData is 0 whenever !(MemRead & Hit).
- Writes with MemWrite & !Hit have no effect.
- MemRead & MemWrite together: the write takes effect; the read returns the pre-write value.
- Change capture:
  - prev_in is a register loaded with sync_out every cycle.
  - When sync_out != prev_in, sync_out is pushed into the FIFO.
- Push/pop rules:
  - Push when full and no pop in the same cycle: the sample is dropped and overflow is set.
  - Push and pop in the same cycle: both are performed and count is unchanged. This also holds when full; overflow is not set.
  - Flush in the same cycle as a push or pop: flush wins. The sample is discarded and overflow is unchanged.
  - Clear-overflow in the same cycle as a new overflow event: overflow ends at 1 (set wins).
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is kept separately, log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset (asynchronous, while reset=0):
  - PortOut=0, synchronizer=0, prev_in=0.
  - FIFO empty, pointers=0, overflow=0, Irq=0.
  - ReadData follows its combinational rule.
- A PortIn change set up before edge k:
  - It is visible in PORT_IN after edge k+SYNC_STAGES-1.
  - It is pushed at edge k+SYNC_STAGES, so Irq=1 from that edge.
- A nonzero PortIn at reset release is captured as a change (prev_in starts at 0).
- PORT_OUT write in cycle n: PortOut holds the new value after edge n. There is no other latency.
- Reads: zero-latency combinational, matching the single-cycle datapath. STATUS reflects state before the current edge.
- Back-to-back FIFO_POP reads on consecutive cycles return consecutive entries.
- Reset asserted mid-operation: all state clears immediately. The FIFO contents are lost, and no pop or push completes.

## Test plan
- **Reset and output port:** assert reset=0; then sw 0xDEADBEEF to BASE+0x00.
  - Expected: PortOut=0 during reset, 0xDEADBEEF after the write edge, and a lw of BASE+0x00 returns 0xDEADBEEF.
- **Input synchronizer and capture:** drive PortIn 0x00→0x5A with SYNC_STAGES=2.
  - Expected: PORT_IN reads 0x5A one edge after the change, Irq rises at the 2nd edge, and STATUS=count 1.
  - Expected: a FIFO_POP read returns 0x5A, then STATUS shows empty and Irq=0.
- **Fill and overflow:** apply 5 distinct PortIn changes (0x01..0x05) with no pops, FIFO_DEPTH=4.
  - Expected: STATUS has full=1, overflow=1, count=4. Pops return 0x01..0x04; a 5th pop returns 0.
  - Then write CTRL=0x1. Expected: overflow=0.
- **Simultaneous push and pop while full:** hold a pop on the same cycle a new change is pushed.
  - Expected: count stays 4, overflow stays 0, and order is preserved across pointer wrap.
- **Flush and decode boundaries:** with 2 entries queued, write CTRL=0x2 in the same cycle as an incoming change.
  - Expected: count=0 and overflow unchanged.
  - Read BASE+0x14. Expected: 0 with Hit=1.
  - Read BASE+0x20. Expected: Hit=0 and ReadData=0.
- **Reset mid-operation:** assert reset with 3 entries queued and PortOut=0x1234.
  - Expected: PortOut=0, FIFO empty and Irq=0 immediately, without waiting for a clock edge.
